// File: rtl/mem_req_rr_arbiter.sv
// Round-robin arbiter feeding one memory-request FIFO from NumReq requesters.
// A grant is held across a multi-beat burst until the beat flagged last,
// and the granted index is pushed with the word for response routing.
module mem_req_rr_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 64,
  parameter int IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  input  logic [NumReq-1:0]             req_last_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic                          push_o,
  output logic [DataWidth-1:0]          push_data_o,
  output logic [IdxWidth-1:0]           push_idx_o,
  input  logic                          full_i,
  output logic                          locked_o,
  output logic [IdxWidth-1:0]           lock_idx_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [IdxWidth-1:0] lock_q, lock_d;
  logic [IdxWidth-1:0] gnt;
  logic                gnt_valid;

  // Index addition modulo NumReq; keeps the pointer in range for non-power-of-two counts.
  function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] base,
                                                   input int off);
    int s;
    s = int'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return IdxWidth'(s);
  endfunction

  // Grant selection: the locker only while LOCKED, otherwise first valid from ptr_q onward.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    if (state_q == LOCKED) begin
      gnt       = lock_q;
      gnt_valid = req_valid_i[lock_q];
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (!gnt_valid && req_valid_i[wrap_add(ptr_q, i)]) begin
          gnt       = wrap_add(ptr_q, i);
          gnt_valid = 1'b1;
        end
      end
    end
  end

  // FIFO push port and per-requester ready; nothing moves during reset or flush.
  always_comb begin
    push_o      = gnt_valid & ~full_i & ~rst_i & ~flush_i;
    push_data_o = '0;
    push_idx_o  = '0;
    if (gnt_valid) begin
      push_data_o = req_data_i[int'(gnt)*DataWidth +: DataWidth];
      push_idx_o  = gnt;
    end
    req_ready_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      req_ready_o[k] = push_o && (gnt == IdxWidth'(k));
    end
  end

  // Next-state: lock on a non-last beat, release and rotate priority on the last beat.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (flush_i) begin
      state_d = IDLE;
      ptr_d   = '0;
      lock_d  = '0;
    end else if (push_o) begin
      if (req_last_i[gnt]) begin
        state_d = IDLE;
        ptr_d   = wrap_add(gnt, 1);
      end else begin
        state_d = LOCKED;
        lock_d  = gnt;
      end
    end
  end

  // State, priority pointer and lock owner registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  assign locked_o   = (state_q == LOCKED);
  assign lock_idx_o = lock_q;

endmodule

// File: tb/tb_mem_req_rr_arbiter.sv
// Directed bench for mem_req_rr_arbiter: a 4-requester and a 3-requester instance.
module tb_mem_req_rr_arbiter;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // 4-requester instance
  logic          rst4, flush4, full4;
  logic [3:0]    valid4, last4, ready4;
  logic [4*DW-1:0] data4;
  logic          push4, locked4;
  logic [DW-1:0] pdata4;
  logic [1:0]    pidx4, lidx4;

  // 3-requester instance
  logic          rst3, flush3, full3;
  logic [2:0]    valid3, last3, ready3;
  logic [3*DW-1:0] data3;
  logic          push3, locked3;
  logic [DW-1:0] pdata3;
  logic [1:0]    pidx3, lidx3;

  mem_req_rr_arbiter #(.NumReq(4), .DataWidth(DW)) dut4 (
    .clk_i(clk), .rst_i(rst4), .flush_i(flush4), .req_valid_i(valid4),
    .req_data_i(data4), .req_last_i(last4), .req_ready_o(ready4),
    .push_o(push4), .push_data_o(pdata4), .push_idx_o(pidx4),
    .full_i(full4), .locked_o(locked4), .lock_idx_o(lidx4)
  );

  mem_req_rr_arbiter #(.NumReq(3), .DataWidth(DW)) dut3 (
    .clk_i(clk), .rst_i(rst3), .flush_i(flush3), .req_valid_i(valid3),
    .req_data_i(data3), .req_last_i(last3), .req_ready_o(ready3),
    .push_o(push3), .push_data_o(pdata3), .push_idx_o(pidx3),
    .full_i(full3), .locked_o(locked3), .lock_idx_o(lidx3)
  );

  function automatic logic [DW-1:0] word(input int k, input int b);
    return DW'(32'hA000 + k * 16 + b);
  endfunction

  // Each requester k presents word(k, beat[k]).
  task automatic load4(input int b0, input int b1, input int b2, input int b3);
    data4[0*DW +: DW] = word(0, b0);
    data4[1*DW +: DW] = word(1, b1);
    data4[2*DW +: DW] = word(2, b2);
    data4[3*DW +: DW] = word(3, b3);
  endtask

  task automatic load3(input int b0, input int b1, input int b2);
    data3[0*DW +: DW] = word(0, b0);
    data3[1*DW +: DW] = word(1, b1);
    data3[2*DW +: DW] = word(2, b2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset4();
    rst4 = 1'b1; flush4 = 1'b0; full4 = 1'b0; valid4 = '0; last4 = '0; load4(0, 0, 0, 0);
    tick();
    rst4 = 1'b0;
  endtask

  task automatic reset3();
    rst3 = 1'b1; flush3 = 1'b0; full3 = 1'b0; valid3 = '0; last3 = '0; load3(0, 0, 0);
    tick();
    rst3 = 1'b0;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; flush4 = 1'b0; full4 = 1'b0; valid4 = '0; last4 = 4'b1111; load4(0, 0, 0, 0);
    tick();
    @(negedge clk);
    total++;
    if ({push4, pidx4, pdata4} !== {1'b0, 2'd0, 16'h0})
      $display("FAIL reset_novalid got push=%b idx=%0d data=%h want 0/0/0000", push4, pidx4, pdata4);
    else passed++;
    tick();
    valid4 = 4'b1111;
    @(negedge clk);
    total++;
    if ({push4, ready4, locked4, lidx4} !== {1'b0, 4'b0000, 1'b0, 2'd0})
      $display("FAIL reset_outputs got push=%b ready=%b locked=%b lidx=%0d want 0/0000/0/0",
               push4, ready4, locked4, lidx4);
    else passed++;
    tick();
    rst4 = 1'b0;
    @(negedge clk);
    total++;
    if ({push4, pidx4, ready4, pdata4} !== {1'b1, 2'd0, 4'b0001, word(0, 0)})
      $display("FAIL reset_first_grant got push=%b idx=%0d ready=%b data=%h want 1/0/0001/%h",
               push4, pidx4, ready4, pdata4, word(0, 0));
    else passed++;
    tick();
    @(negedge clk);
    total++;
    if ({push4, pidx4, ready4} !== {1'b1, 2'd1, 4'b0010})
      $display("FAIL reset_ptr_after_last got push=%b idx=%0d ready=%b want 1/1/0010", push4, pidx4, ready4);
    else passed++;
  endtask

  task automatic test_round_robin();
    reset4();
    valid4 = 4'b1111; last4 = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({push4, pidx4, ready4, pdata4} !== {1'b1, 2'(i % 4), 4'(1 << (i % 4)), word(i % 4, 0)})
        $display("FAIL rr_cycle%0d got push=%b idx=%0d ready=%b data=%h want 1/%0d/%b/%h",
                 i, push4, pidx4, ready4, pdata4, i % 4, 4'(1 << (i % 4)), word(i % 4, 0));
      else passed++;
      tick();
    end
  endtask

  task automatic test_burst_lock();
    logic [1:0] exp_idx [5];
    logic       exp_lck [5];
    exp_idx = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
    exp_lck = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    reset4();
    // Two single beats from 0 and 1 move the pointer to 2.
    valid4 = 4'b0011; last4 = 4'b1111;
    tick(); tick();
    valid4 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      last4 = (i < 2) ? 4'b1011 : 4'b1111;
      load4(0, 0, (i < 3) ? i : 0, 0);
      @(negedge clk);
      total++;
      if ({push4, pidx4, locked4, pdata4} !==
          {1'b1, exp_idx[i], exp_lck[i], word(int'(exp_idx[i]), (i < 3) ? i : 0)})
        $display("FAIL burst_cycle%0d got push=%b idx=%0d locked=%b data=%h want 1/%0d/%b/%h",
                 i, push4, pidx4, locked4, pdata4, exp_idx[i], exp_lck[i],
                 word(int'(exp_idx[i]), (i < 3) ? i : 0));
      else passed++;
      if (i == 1) begin
        total++;
        if (lidx4 !== 2'd2) $display("FAIL burst_lock_idx got %0d want 2", lidx4);
        else passed++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    reset4();
    valid4 = 4'b0010; last4 = 4'b0000;
    tick();
    valid4 = 4'b1111; last4 = 4'b1101; load4(0, 1, 0, 0); full4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({push4, ready4, locked4, lidx4, pidx4, pdata4} !==
          {1'b0, 4'b0000, 1'b1, 2'd1, 2'd1, word(1, 1)})
        $display("FAIL bp_stall%0d got push=%b ready=%b locked=%b lidx=%0d idx=%0d data=%h want 0/0000/1/1/1/%h",
                 i, push4, ready4, locked4, lidx4, pidx4, pdata4, word(1, 1));
      else passed++;
      tick();
    end
    full4 = 1'b0; last4 = 4'b1111;
    @(negedge clk);
    total++;
    if ({push4, pidx4, ready4, pdata4} !== {1'b1, 2'd1, 4'b0010, word(1, 1)})
      $display("FAIL bp_resume got push=%b idx=%0d ready=%b data=%h want 1/1/0010/%h",
               push4, pidx4, ready4, pdata4, word(1, 1));
    else passed++;
    tick();
    load4(0, 0, 0, 0);
    @(negedge clk);
    total++;
    if ({push4, pidx4, locked4} !== {1'b1, 2'd2, 1'b0})
      $display("FAIL bp_next_grant got push=%b idx=%0d locked=%b want 1/2/0", push4, pidx4, locked4);
    else passed++;
    tick();
  endtask

  task automatic test_locker_idle();
    reset4();
    valid4 = 4'b0001; last4 = 4'b0000;
    tick();
    valid4 = 4'b1000; last4 = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({push4, ready4, locked4, lidx4} !== {1'b0, 4'b0000, 1'b1, 2'd0})
        $display("FAIL idle_wait%0d got push=%b ready=%b locked=%b lidx=%0d want 0/0000/1/0",
                 i, push4, ready4, locked4, lidx4);
      else passed++;
      tick();
    end
    valid4 = 4'b1001; last4 = 4'b1001; load4(1, 0, 0, 0);
    @(negedge clk);
    total++;
    if ({push4, pidx4, ready4, pdata4} !== {1'b1, 2'd0, 4'b0001, word(0, 1)})
      $display("FAIL idle_return got push=%b idx=%0d ready=%b data=%h want 1/0/0001/%h",
               push4, pidx4, ready4, pdata4, word(0, 1));
    else passed++;
    tick();
    valid4 = 4'b1000;
    @(negedge clk);
    total++;
    if ({push4, pidx4, ready4} !== {1'b1, 2'd3, 4'b1000})
      $display("FAIL idle_then_3 got push=%b idx=%0d ready=%b want 1/3/1000", push4, pidx4, ready4);
    else passed++;
    tick();
  endtask

  task automatic test_flush_nonpow2();
    logic [1:0] exp_idx [4];
    exp_idx = '{2'd0, 2'd1, 2'd2, 2'd0};
    reset3();
    valid3 = 3'b100; last3 = 3'b000;
    @(negedge clk);
    total++;
    if ({push3, pidx3, ready3} !== {1'b1, 2'd2, 3'b100})
      $display("FAIL np_burst_start got push=%b idx=%0d ready=%b want 1/2/100", push3, pidx3, ready3);
    else passed++;
    tick();
    valid3 = 3'b111; flush3 = 1'b1;
    @(negedge clk);
    total++;
    if ({push3, ready3, locked3, lidx3} !== {1'b0, 3'b000, 1'b1, 2'd2})
      $display("FAIL np_flush_cycle got push=%b ready=%b locked=%b lidx=%0d want 0/000/1/2",
               push3, ready3, locked3, lidx3);
    else passed++;
    tick();
    flush3 = 1'b0; last3 = 3'b111;
    @(negedge clk);
    total++;
    if ({locked3, lidx3, push3, pidx3} !== {1'b0, 2'd0, 1'b1, 2'd0})
      $display("FAIL np_after_flush got locked=%b lidx=%0d push=%b idx=%0d want 0/0/1/0",
               locked3, lidx3, push3, pidx3);
    else passed++;
    // Wrap: a single beat from 2 must rotate priority back to 0.
    reset3();
    valid3 = 3'b100; last3 = 3'b111;
    tick();
    valid3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({push3, pidx3, ready3} !== {1'b1, exp_idx[i], 3'(1 << int'(exp_idx[i]))})
        $display("FAIL np_wrap%0d got push=%b idx=%0d ready=%b want 1/%0d/%b",
                 i, push3, pidx3, ready3, exp_idx[i], 3'(1 << int'(exp_idx[i])));
      else passed++;
      tick();
    end
  endtask

  initial begin
    rst3 = 1'b1; flush3 = 1'b0; full3 = 1'b0; valid3 = '0; last3 = '0; load3(0, 0, 0);
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_backpressure();
    test_locker_idle();
    test_flush_nonpow2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_req_rr_arbiter.md
# mem_req_rr_arbiter

Round-robin arbiter that shares one memory-request FIFO between `NumReq` requesters in the axi_to_mem path. Each requester presents a packed request word with valid/ready. The arbiter grants one requester at a time and holds the grant for a multi-beat burst until the beat marked `last`. It drives the FIFO push port, appends the granted requester index for response routing, and respects FIFO back-pressure via `full_i`.

## Interface
Parameters:
- `NumReq`, 4: number of requesters, ≥1.
- `DataWidth`, 64: width of one request word (FIFO payload, excluding index).
- `IdxWidth`, `NumReq>1 ? $clog2(NumReq) : 1`: width of the granted index.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `flush_i` in 1: synchronous abort. Drops the lock and resets the priority pointer.
- `req_valid_i` in `NumReq`: per-requester valid.
- `req_data_i` in `NumReq*DataWidth`: request words. Requester k occupies `[k*DataWidth +: DataWidth]`.
- `req_last_i` in `NumReq`: the current beat is the last of its burst.
- `req_ready_o` out `NumReq`: the beat is accepted this cycle.
- `push_o` out 1: FIFO push strobe.
- `push_data_o` out `DataWidth`: word pushed.
- `push_idx_o` out `IdxWidth`: index of the granted requester, pushed alongside the data.
- `full_i` in 1: FIFO full.
- `locked_o` out 1: state is LOCKED.
- `lock_idx_o` out `IdxWidth`: requester holding the lock.

## Operation
Registered state:
- `state_q` ∈ {IDLE, LOCKED}.
- `ptr_q` (`IdxWidth`): highest-priority index.
- `lock_q` (`IdxWidth`).

Grant selection (combinational):
- IDLE: the first set bit of `req_valid_i`, scanning `ptr_q`, `ptr_q+1`, …, wrapping from `NumReq-1` to 0. `gnt_valid` = any valid.
- LOCKED: `gnt = lock_q`; `gnt_valid = req_valid_i[lock_q]`. All other requesters are ineligible.

Outputs:
- `push_o = gnt_valid & ~full_i & ~rst_i & ~flush_i`.
- `push_data_o` = word of `gnt`.
- `push_idx_o = gnt`.
- `push_data_o` and `push_idx_o` are don't-care when `push_o=0`, but are driven 0 when `gnt_valid=0`.
- `req_ready_o[k] = push_o & (gnt==k)`. One-hot or zero.

A transfer ("xfer") occurs when `push_o=1`. State update on a clock edge with an xfer on `gnt`:
- `req_last_i[gnt]=0`: `state_q←LOCKED`, `lock_q←gnt`. `ptr_q` is unchanged.
- `req_last_i[gnt]=1`: `state_q←IDLE`. `ptr_q←gnt+1`, wrapping `NumReq-1→0`.

No xfer: state holds. This includes LOCKED with the locker's valid low; the arbiter waits, and other requesters stay blocked.

Index arithmetic is mod `NumReq`. This covers non-power-of-two `NumReq`: `ptr_q` never holds a value ≥`NumReq`.

With `NumReq=1`, the grant is always 0. LOCKED still tracks the burst, but has no effect on fairness.

`rst_i` or `flush_i` (`rst_i` has precedence; both give the same result):
- `state_q←IDLE`, `ptr_q←0`, `lock_q←0`.
- No xfer occurs in that cycle.
- A burst interrupted mid-way is abandoned. Its beats already pushed stay in the FIFO; flushing the FIFO is the owner's job.

Requester rules:
- Once asserted, valid and data/last stay stable until ready.
- `req_ready_o` does not depend on the requester's own `req_valid_i` except through the grant. There is no combinational loop from ready to valid.

## Timing
- Zero-cycle latency: `req_valid_i`→`push_o` and `req_ready_o` are combinational paths, as is `full_i`→`push_o`.
- Grant/lock/pointer changes take effect the cycle after the xfer edge.
- Throughput: one beat per cycle while `full_i=0`. Back-to-back bursts from different requesters incur no bubble.
- Reset values:
  - `push_o=0`, `req_ready_o=0`, `locked_o=0`, `lock_idx_o=0`.
  - `push_idx_o=0` and `push_data_o=0` while no request is valid.
- `full_i=1`: no xfer, no state change. The grant is recomputed each cycle in IDLE, so in IDLE a higher-priority late arrival may take the slot.
- `locked_o=(state_q==LOCKED)`, `lock_idx_o=lock_q`. Both are registered.

## Test plan
- **Reset:** `NumReq=4`, `rst_i=1`, all valid high → `push_o=0`, `ready=0000`. Release → cycle 1 grants requester 0; after its last beat, `ptr_q=1`.
- **Round-robin:** all 4 hold single-beat requests continuously, `full_i=0` → grant order 0,1,2,3,0,1; `push_idx_o` matches; one push per cycle.
- **Burst lock:** requester 2 sends 3 beats (`last` on the 3rd) while 0,1,3 are valid → three consecutive pushes with `idx=2` and `locked_o=1` for 2 cycles. Then grant goes to 3, then 0.
- **Back-pressure mid-burst:** requester 1 in LOCKED with `full_i=1` for 3 cycles, other valids high → `push_o=0`, `lock_idx_o` stays 1, no other grant. Release → the burst resumes with the same data.
- **Locker idle:** requester 0 LOCKED drops valid for 2 cycles while 3 is valid → no pushes. Requester 0 returns with `last` → push; then 3 is granted.
- **Flush / non-pow2:** `NumReq=3`, flush mid-burst of requester 2 → `locked_o=0`, `ptr_q=0` next cycle. Wrap check: single beats from 2 → next grant is 0, never 3.
